// File: rtl/order_msg_dispatch.sv
// order_msg_dispatch: turns parsed ITCH order messages into order-book add and
// delete/execute requests. Adds are stored in an order-reference map and
// forwarded directly; delete/execute/cancel look the order up and forward the
// stored locate/price/side with the number of shares to remove.
module order_msg_dispatch #(
   parameter int MAP_ADDR_BITS = 10
) (
   input  logic        clkIn,
   input  logic        rstIn,
   input  logic        msgValidIn,
   output logic        msgReadyOut,
   input  logic [1:0]  msgTypeIn,
   input  logic [63:0] orderRefIn,
   input  logic [15:0] locateIn,
   input  logic [31:0] priceIn,
   input  logic [31:0] sharesIn,
   input  logic        buySellIn,
   output logic        addValidOut,
   output logic        delExecValidOut,
   output logic [15:0] locateOut,
   output logic [31:0] priceOut,
   output logic [31:0] sharesOut,
   output logic        buySellOut,
   output logic [15:0] mapLocateOut,
   output logic [31:0] mapPriceOut,
   output logic [31:0] mapSharesOut,
   output logic        mapBuySellOut,
   output logic [15:0] missCountOut,
   output logic [15:0] collisionCountOut
);

   localparam int        DEPTH    = 1 << MAP_ADDR_BITS;
   localparam int        DW       = 81;   // {locate16, price32, shares32, side1}
   localparam logic [1:0] T_ADD    = 2'd0;
   localparam logic [1:0] T_DELETE = 2'd1;

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE} state_t;

   state_t                   r_state, w_state_next;
   logic                     r_run;          // low until the first edge after reset
   logic [DW-1:0]            r_mem [DEPTH];  // map payload, never reset
   logic [DEPTH-1:0]         r_valid;        // map valid bits, cleared by reset
   logic [1:0]               r_type;
   logic [MAP_ADDR_BITS-1:0] r_idx;
   logic [31:0]              r_shares;
   logic [DW-1:0]            r_rd_data;
   logic                     r_rd_valid;

   logic                     w_accept, w_add_fire, w_lookup_fire, w_upd_fire, w_clear;
   logic [MAP_ADDR_BITS-1:0] w_in_idx;
   logic [15:0]              w_st_loc;
   logic [31:0]              w_st_px, w_st_sh, w_take, w_remain;
   logic                     w_st_bs;
   logic                     w_we;
   logic [MAP_ADDR_BITS-1:0] w_waddr;
   logic [DW-1:0]            w_wdata;
   logic                     w_unused_ref_bits;

   assign w_in_idx          = orderRefIn[MAP_ADDR_BITS-1:0];
   assign w_unused_ref_bits = ^orderRefIn[63:MAP_ADDR_BITS];
   assign w_accept          = msgValidIn & msgReadyOut;
   assign w_add_fire        = w_accept & (msgTypeIn == T_ADD);
   assign w_lookup_fire     = w_accept & (msgTypeIn != T_ADD);

   assign {w_st_loc, w_st_px, w_st_sh, w_st_bs} = r_rd_data;

   // Shares removed: whole order on delete, clamped request on execute/cancel.
   assign w_take     = (r_type == T_DELETE) ? w_st_sh :
                       ((r_shares < w_st_sh) ? r_shares : w_st_sh);
   assign w_remain   = w_st_sh - w_take;
   assign w_upd_fire = (r_state == S_UPDATE) & r_rd_valid;
   // A zero-share execute/cancel leaves the entry untouched.
   assign w_clear    = w_upd_fire & ((r_type == T_DELETE) | ((w_remain == 32'd0) & (w_take != 32'd0)));

   // Single map write port: adds in IDLE, remaining-share updates in UPDATE.
   assign w_we    = w_add_fire | w_upd_fire;
   assign w_waddr = w_add_fire ? w_in_idx : r_idx;
   assign w_wdata = w_add_fire ? {locateIn, priceIn, sharesIn, buySellIn}
                               : {w_st_loc, w_st_px, w_remain, w_st_bs};

   // Map payload RAM with registered read in LOOKUP.
   always_ff @(posedge clkIn) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
      if (r_state == S_LOOKUP) r_rd_data <= r_mem[r_idx];
   end

   // Valid bits, lookup capture and the registered valid read.
   always_ff @(posedge clkIn or negedge rstIn) begin
      if (!rstIn) begin
         r_valid    <= '0;
         r_rd_valid <= 1'b0;
         r_type     <= 2'd0;
         r_idx      <= '0;
         r_shares   <= 32'd0;
      end else begin
         if (w_add_fire)   r_valid[w_in_idx] <= 1'b1;
         else if (w_clear) r_valid[r_idx]    <= 1'b0;
         if (w_lookup_fire) begin
            r_type   <= msgTypeIn;
            r_idx    <= w_in_idx;
            r_shares <= sharesIn;
         end
         if (r_state == S_LOOKUP) r_rd_valid <= r_valid[r_idx];
      end
   end

   // FSM state register plus the post-reset run flag.
   always_ff @(posedge clkIn or negedge rstIn) begin
      if (!rstIn) begin
         r_state <= S_IDLE;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_run   <= 1'b1;
      end
   end

   // FSM next state: only non-add messages leave IDLE.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (w_lookup_fire) w_state_next = S_LOOKUP;
         S_LOOKUP: w_state_next = S_UPDATE;
         S_UPDATE: w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   // FSM outputs: accept only in IDLE once out of reset.
   always_comb begin
      msgReadyOut = (r_state == S_IDLE) && r_run;
   end

   // Registered order-book outputs and saturating counters.
   always_ff @(posedge clkIn or negedge rstIn) begin
      if (!rstIn) begin
         addValidOut       <= 1'b0;
         delExecValidOut   <= 1'b0;
         locateOut         <= 16'd0;
         priceOut          <= 32'd0;
         sharesOut         <= 32'd0;
         buySellOut        <= 1'b0;
         mapLocateOut      <= 16'd0;
         mapPriceOut       <= 32'd0;
         mapSharesOut      <= 32'd0;
         mapBuySellOut     <= 1'b0;
         missCountOut      <= 16'd0;
         collisionCountOut <= 16'd0;
      end else begin
         addValidOut     <= w_add_fire;
         delExecValidOut <= w_upd_fire;
         if (w_add_fire) begin
            locateOut  <= locateIn;
            priceOut   <= priceIn;
            sharesOut  <= sharesIn;
            buySellOut <= buySellIn;
            if (r_valid[w_in_idx] && (collisionCountOut != 16'hFFFF))
               collisionCountOut <= collisionCountOut + 16'd1;
         end
         if (w_upd_fire) begin
            mapLocateOut  <= w_st_loc;
            mapPriceOut   <= w_st_px;
            mapSharesOut  <= w_take;
            mapBuySellOut <= w_st_bs;
         end
         if ((r_state == S_UPDATE) && !r_rd_valid && (missCountOut != 16'hFFFF))
            missCountOut <= missCountOut + 16'd1;
      end
   end

endmodule

// File: tb/tb_order_msg_dispatch.sv
// tb_order_msg_dispatch: directed and random ITCH messages; expected order-book
// pulses come from an order map kept as an associative array and are checked
// by an independent monitor against a queue of expected transactions.
module tb_order_msg_dispatch;

   localparam int AB    = 10;
   localparam int DEPTH = 1 << AB;

   logic        clkIn = 1'b0;
   logic        rstIn = 1'b0;
   logic        msgValidIn = 1'b0;
   logic        msgReadyOut;
   logic [1:0]  msgTypeIn = 2'd0;
   logic [63:0] orderRefIn = 64'd0;
   logic [15:0] locateIn = 16'd0;
   logic [31:0] priceIn = 32'd0;
   logic [31:0] sharesIn = 32'd0;
   logic        buySellIn = 1'b0;
   logic        addValidOut, delExecValidOut;
   logic [15:0] locateOut, mapLocateOut;
   logic [31:0] priceOut, sharesOut, mapPriceOut, mapSharesOut;
   logic        buySellOut, mapBuySellOut;
   logic [15:0] missCountOut, collisionCountOut;

   order_msg_dispatch #(.MAP_ADDR_BITS(AB)) dut (
      .clkIn(clkIn), .rstIn(rstIn), .msgValidIn(msgValidIn), .msgReadyOut(msgReadyOut),
      .msgTypeIn(msgTypeIn), .orderRefIn(orderRefIn), .locateIn(locateIn),
      .priceIn(priceIn), .sharesIn(sharesIn), .buySellIn(buySellIn),
      .addValidOut(addValidOut), .delExecValidOut(delExecValidOut),
      .locateOut(locateOut), .priceOut(priceOut), .sharesOut(sharesOut), .buySellOut(buySellOut),
      .mapLocateOut(mapLocateOut), .mapPriceOut(mapPriceOut), .mapSharesOut(mapSharesOut),
      .mapBuySellOut(mapBuySellOut), .missCountOut(missCountOut),
      .collisionCountOut(collisionCountOut)
   );

   always #5 clkIn = ~clkIn;

   int cyc = 0;
   always @(posedge clkIn) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [15:0] loc;
      logic [31:0] px;
      logic [31:0] rem;
      logic        bs;
   } ord_t;

   typedef struct {
      bit          is_del;
      int          cyc;
      logic [15:0] loc;
      logic [31:0] px;
      logic [31:0] sh;
      logic        bs;
   } exp_t;

   ord_t        book[int];
   exp_t        exp_q[$];
   logic [15:0] miss_m = 16'd0;
   logic [15:0] coll_m = 16'd0;

   // Apply one accepted message to the model; c is the cycle of acceptance.
   task automatic model_msg(input logic [1:0] typ, input logic [63:0] ref_n,
                            input logic [15:0] loc, input logic [31:0] px,
                            input logic [31:0] sh, input logic bs, input int c);
      int   idx;
      ord_t o;
      exp_t e;
      logic [31:0] take;
      idx = int'(ref_n % 64'(DEPTH));
      if (typ == 2'd0) begin
         if (book.exists(idx) && coll_m != 16'hFFFF) coll_m++;
         o.loc = loc; o.px = px; o.rem = sh; o.bs = bs;
         book[idx] = o;
         e.is_del = 1'b0; e.cyc = c + 1; e.loc = loc; e.px = px; e.sh = sh; e.bs = bs;
         exp_q.push_back(e);
      end else if (!book.exists(idx)) begin
         if (miss_m != 16'hFFFF) miss_m++;
      end else begin
         o = book[idx];
         if (typ == 2'd1) take = o.rem;
         else             take = (sh < o.rem) ? sh : o.rem;
         e.is_del = 1'b1; e.cyc = c + 3; e.loc = o.loc; e.px = o.px; e.sh = take; e.bs = o.bs;
         exp_q.push_back(e);
         o.rem = o.rem - take;
         if (typ == 2'd1 || (o.rem == 0 && take != 0)) book.delete(idx);
         else book[idx] = o;
      end
   endtask

   // ---------------- driver ----------------
   task automatic send(input logic [1:0] typ, input logic [63:0] ref_n, input logic [15:0] loc,
                       input logic [31:0] px, input logic [31:0] sh, input logic bs);
      int waited = 0;
      @(negedge clkIn);
      msgTypeIn = typ; orderRefIn = ref_n; locateIn = loc;
      priceIn = px; sharesIn = sh; buySellIn = bs; msgValidIn = 1'b1;
      while (!msgReadyOut && waited < 20) begin
         @(negedge clkIn);
         waited++;
      end
      if (!msgReadyOut) begin
         chk("ready_timeout", {95'd0, msgReadyOut}, 96'd1);
         msgValidIn = 1'b0;
      end else begin
         model_msg(typ, ref_n, loc, px, sh, bs, cyc);
         @(posedge clkIn);
         #1 msgValidIn = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clkIn);
   endtask

   task automatic chk_counters(input string tag);
      idle(5);
      chk({tag, "_miss"}, {80'd0, missCountOut}, {80'd0, miss_m});
      chk({tag, "_coll"}, {80'd0, collisionCountOut}, {80'd0, coll_m});
   endtask

   // ---------------- monitor ----------------
   logic [80:0] last_add = '0;
   logic [80:0] last_map = '0;

   always @(negedge clkIn) begin
      exp_t e;
      logic exp_add, exp_del;
      if (!rstIn) begin
         last_add = '0;
         last_map = '0;
      end else begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            chk("pulse_by_cycle", 96'(cyc), 96'(exp_q[0].cyc));
            void'(exp_q.pop_front());
         end
         exp_add = (exp_q.size() > 0) && (exp_q[0].cyc == cyc) && !exp_q[0].is_del;
         exp_del = (exp_q.size() > 0) && (exp_q[0].cyc == cyc) && exp_q[0].is_del;
         chk("pulse_flags", {94'd0, addValidOut, delExecValidOut}, {94'd0, exp_add, exp_del});
         if ((exp_add || exp_del) && addValidOut == exp_add && delExecValidOut == exp_del) begin
            e = exp_q.pop_front();
            if (e.is_del) begin
               chk("map_data", {15'd0, mapLocateOut, mapPriceOut, mapSharesOut, mapBuySellOut},
                               {15'd0, e.loc, e.px, e.sh, e.bs});
               $display("cyc %0d delexec loc=%0d px=%0d sh=%0d bs=%0d", cyc,
                        mapLocateOut, mapPriceOut, mapSharesOut, mapBuySellOut);
            end else begin
               chk("add_data", {15'd0, locateOut, priceOut, sharesOut, buySellOut},
                               {15'd0, e.loc, e.px, e.sh, e.bs});
               $display("cyc %0d add     loc=%0d px=%0d sh=%0d bs=%0d", cyc,
                        locateOut, priceOut, sharesOut, buySellOut);
            end
         end
         if (!addValidOut)
            chk("add_hold", {15'd0, locateOut, priceOut, sharesOut, buySellOut}, {15'd0, last_add});
         if (!delExecValidOut)
            chk("map_hold", {15'd0, mapLocateOut, mapPriceOut, mapSharesOut, mapBuySellOut}, {15'd0, last_map});
         last_add = {locateOut, priceOut, sharesOut, buySellOut};
         last_map = {mapLocateOut, mapPriceOut, mapSharesOut, mapBuySellOut};
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [63:0] r;
      logic [1:0]  t;
      // Reset state
      #12;
      chk("rst_ready", {95'd0, msgReadyOut}, 96'd0);
      chk("rst_pulses", {94'd0, addValidOut, delExecValidOut}, 96'd0);
      chk("rst_counters", {64'd0, missCountOut, collisionCountOut}, 96'd0);
      @(negedge clkIn);
      rstIn = 1'b1;
      idle(2);
      chk("ready_after_rst", {95'd0, msgReadyOut}, 96'd1);

      // Add, execute, delete, then a miss on the now-invalid entry
      send(2'd0, 64'd5, 16'd7, 32'd1000, 32'd300, 1'b1);
      send(2'd2, 64'd5, 16'd0, 32'd0, 32'd100, 1'b0);
      send(2'd1, 64'd5, 16'd0, 32'd0, 32'd0, 1'b0);
      send(2'd1, 64'd5, 16'd0, 32'd0, 32'd0, 1'b0);
      // Cancel clamps to remaining and clears the entry
      send(2'd0, 64'd9, 16'd2, 32'd555, 32'd50, 1'b0);
      send(2'd3, 64'd9, 16'd0, 32'd0, 32'd80, 1'b0);
      send(2'd1, 64'd9, 16'd0, 32'd0, 32'd0, 1'b0);
      chk_counters("after_cancel");
      chk("miss_is_two", {80'd0, missCountOut}, 96'd2);
      // Aliasing adds collide; delete returns the second add
      send(2'd0, 64'd3, 16'd1, 32'd111, 32'd10, 1'b1);
      send(2'd0, 64'd3 + 64'(DEPTH), 16'd4, 32'd222, 32'd20, 1'b0);
      send(2'd1, 64'd3, 16'd0, 32'd0, 32'd0, 1'b0);
      chk_counters("after_collision");
      chk("coll_is_one", {80'd0, collisionCountOut}, 96'd1);
      // Add immediately followed by a delete of the same reference
      send(2'd0, 64'd20, 16'd8, 32'd777, 32'd77, 1'b1);
      send(2'd1, 64'd20, 16'd0, 32'd0, 32'd0, 1'b0);
      // Zero-share execute keeps the entry; a full execute then clears it
      send(2'd0, 64'd30, 16'd9, 32'd900, 32'd40, 1'b0);
      send(2'd2, 64'd30, 16'd0, 32'd0, 32'd0, 1'b0);
      send(2'd2, 64'd30, 16'd0, 32'd0, 32'd40, 1'b0);
      send(2'd1, 64'd30, 16'd0, 32'd0, 32'd0, 1'b0);
      chk_counters("after_zero_exec");

      // Reset while a delete is in LOOKUP
      send(2'd0, 64'd40, 16'd5, 32'd400, 32'd4, 1'b1);
      send(2'd0, 64'd41, 16'd6, 32'd410, 32'd5, 1'b0);
      idle(2);
      send(2'd1, 64'd40, 16'd0, 32'd0, 32'd0, 1'b0);
      #2 rstIn = 1'b0;
      exp_q.delete();
      book.delete();
      miss_m = 16'd0;
      coll_m = 16'd0;
      #1;
      chk("midrst_ready", {95'd0, msgReadyOut}, 96'd0);
      chk("midrst_counters", {64'd0, missCountOut, collisionCountOut}, 96'd0);
      idle(3);
      chk("midrst_no_pulse", {94'd0, addValidOut, delExecValidOut}, 96'd0);
      rstIn = 1'b1;
      idle(2);
      chk("postrst_ready", {95'd0, msgReadyOut}, 96'd1);
      send(2'd1, 64'd41, 16'd0, 32'd0, 32'd0, 1'b0);
      send(2'd3, 64'd40, 16'd0, 32'd0, 32'd3, 1'b0);
      send(2'd1, 64'd5, 16'd0, 32'd0, 32'd0, 1'b0);
      chk_counters("after_midrst");

      // Random traffic over a few indices, with aliasing upper bits
      for (int i = 0; i < 300; i++) begin
         r = ({$urandom, $urandom} & ~64'(DEPTH - 1)) | 64'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 0) r = r % 64'(DEPTH);
         t = 2'($urandom_range(0, 3));
         if (t == 2'd0)
            send(t, r, 16'($urandom), $urandom, 32'($urandom_range(1, 500)), 1'($urandom));
         else
            send(t, r, 16'($urandom), $urandom, 32'($urandom_range(0, 400)), 1'($urandom));
         if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      end
      chk_counters("final");
      chk("queue_drained", 96'(exp_q.size()), 96'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
